// File: rtl/muxn_skid_pkg.sv
// Shared constants for the N-way select / skid pipeline stage.
// Bounds on the input count are checked when the top module elaborates.
package muxn_skid_pkg;

   localparam int MUXN_MIN_IN = 2;
   localparam int MUXN_MAX_IN = 16;

   function automatic bit muxn_num_in_ok(input int n);
      return (n >= MUXN_MIN_IN) && (n <= MUXN_MAX_IN);
   endfunction

endpackage

// File: rtl/muxn_skid_sel.sv
// Purely combinational N-way selector; out-of-range selects return zero
// and raise o_sel_bad so the caller can account for the error beat.
module muxn_sel
   import muxn_skid_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_IN     = 4,
   parameter int SEL_WIDTH  = 2
) (
   input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
   input  logic [SEL_WIDTH-1:0]         i_sel,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_sel_bad
);

   always_comb begin
      o_data    = '0;
      o_sel_bad = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (i_sel == SEL_WIDTH'(k)) begin
            o_data    = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            o_sel_bad = 1'b0;
         end
      end
   end

endmodule

// File: rtl/muxn_skid.sv
// N-way data selector feeding a registered ready/valid stage with a skid
// register, flush, and sticky/saturating bad-select reporting.
module muxn_skid
   import muxn_skid_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_IN        = 4,
   parameter  int ERR_CNT_WIDTH = 8,
   localparam int SEL_WIDTH     = $clog2(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [SEL_WIDTH-1:0]         in_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         sel_err,
   input  logic                         err_clr,
   output logic [ERR_CNT_WIDTH-1:0]     err_count
);

   if (!muxn_num_in_ok(NUM_IN)) begin : g_bad_num_in
      $error("muxn_skid: NUM_IN=%0d outside %0d..%0d", NUM_IN, MUXN_MIN_IN, MUXN_MAX_IN);
   end

   logic [DATA_WIDTH-1:0]    r_main_data;
   logic                     r_main_valid;
   logic [DATA_WIDTH-1:0]    r_skid_data;
   logic                     r_skid_valid;
   logic                     r_sel_err;
   logic [ERR_CNT_WIDTH-1:0] r_err_count;

   logic [DATA_WIDTH-1:0]    w_sel_data;
   logic                     w_sel_bad;
   logic                     w_acc;
   logic                     w_drain;
   logic                     w_err_beat;

   muxn_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_IN     (NUM_IN),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_sel (
      .i_data    (in_data),
      .i_sel     (in_sel),
      .o_data    (w_sel_data),
      .o_sel_bad (w_sel_bad)
   );

   // Ready depends only on the skid flop, so out_ready never reaches in_ready.
   assign w_acc      = in_valid & ~r_skid_valid & ~flush;
   assign w_drain    = r_main_valid & out_ready;
   assign w_err_beat = w_acc & w_sel_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_data  <= '0;
         r_main_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_drain) begin
         // Main is free this edge; the skid beat is older than any new one.
         if (r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_acc) begin
            r_main_data  <= w_sel_data;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_acc) begin
         r_skid_data  <= w_sel_data;
         r_skid_valid <= 1'b1;
      end
   end

   // A clear discards the old count but still records a coincident error beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_err   <= 1'b0;
         r_err_count <= '0;
      end else if (err_clr) begin
         r_sel_err   <= w_err_beat;
         r_err_count <= ERR_CNT_WIDTH'(w_err_beat);
      end else if (w_err_beat) begin
         r_sel_err <= 1'b1;
         if (r_err_count != '1) begin
            r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
         end
      end
   end

   assign in_ready  = ~r_skid_valid;
   assign out_data  = r_main_data;
   assign out_valid = r_main_valid;
   assign sel_err   = r_sel_err;
   assign err_count = r_err_count;

endmodule
